// File: rtl/spi_responder_if.sv
// Pin and byte-stream bundle of the flash-side SPI responder.
// The slave modport is the responder; the master modport is whoever drives the pins and consumes the bytes.
interface spi_responder_if;
    logic       spi_cs_n;
    logic       spi_clk;
    logic [3:0] spi_data_in;
    logic [3:0] spi_data_out;
    logic [3:0] spi_data_oe;
    logic [2:0] spi_mode_in;
    logic       spi_drive_in;
    logic       spi_byte_tx_strobe;
    logic [7:0] spi_byte_tx;
    logic       spi_tx_ready;
    logic       spi_tx_underrun;
    logic       spi_byte_rx_strobe;
    logic [7:0] spi_byte_rx;
    logic       spi_cs_start;
    logic       spi_cs_end;

    modport slave (
        input  spi_cs_n, spi_clk, spi_data_in, spi_mode_in, spi_drive_in,
               spi_byte_tx_strobe, spi_byte_tx,
        output spi_data_out, spi_data_oe, spi_tx_ready, spi_tx_underrun,
               spi_byte_rx_strobe, spi_byte_rx, spi_cs_start, spi_cs_end
    );

    modport master (
        output spi_cs_n, spi_clk, spi_data_in, spi_mode_in, spi_drive_in,
               spi_byte_tx_strobe, spi_byte_tx,
        input  spi_data_out, spi_data_oe, spi_tx_ready, spi_tx_underrun,
               spi_byte_rx_strobe, spi_byte_rx, spi_cs_start, spi_cs_end
    );
endinterface

// File: rtl/spi_responder.sv
// Flash-side SPI mode-0 endpoint (single/dual/quad): synchronizes the host pins,
// assembles received bytes and shifts out bytes from a one-deep holding register.
module spi_responder #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset,
    spi_responder_if.slave bus
);
    localparam logic [0:0]        IDLE      = 1'b0;
    localparam logic [0:0]        ACTIVE    = 1'b1;
    localparam int unsigned       SYNC_W    = 6;
    localparam logic [SYNC_W-1:0] SYNC_IDLE = 6'b10_0000;

    logic [SYNC_STAGES-1:0][SYNC_W-1:0] sync_q;
    logic       cs_s, sclk_s;
    logic [3:0] din_s;
    logic       cs_prev_q, sclk_prev_q;

    logic [0:0] state_q, state_d;
    logic [2:0] bits_q, bits_d;
    logic [2:0] mode_q, mode_d;
    logic       drive_q, drive_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_strobe_q, rx_strobe_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] hold_q, hold_d;
    logic       tx_ready_q, tx_ready_d;
    logic       underrun_q, underrun_d;
    logic       cs_start_q, cs_start_d;
    logic       cs_end_q, cs_end_d;
    logic [3:0] data_out_q, data_out_d;
    logic [3:0] oe_q, oe_d;

    logic       cs_fall, cs_rise, sclk_rise, sclk_fall, load_tx;
    logic [2:0] mode_in_norm, bits_sum;
    logic [7:0] rx_next, tx_next;
    logic [3:0] lanes;

    assign cs_s   = sync_q[SYNC_STAGES-1][5];
    assign sclk_s = sync_q[SYNC_STAGES-1][4];
    assign din_s  = sync_q[SYNC_STAGES-1][3:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= SYNC_IDLE;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
            state_q     <= IDLE;
            bits_q      <= 3'd0;
            mode_q      <= 3'd1;
            drive_q     <= 1'b0;
            rx_shift_q  <= 7'd0;
            rx_byte_q   <= 8'd0;
            rx_strobe_q <= 1'b0;
            tx_shift_q  <= 8'd0;
            hold_q      <= 8'd0;
            tx_ready_q  <= 1'b1;
            underrun_q  <= 1'b0;
            cs_start_q  <= 1'b0;
            cs_end_q    <= 1'b0;
            data_out_q  <= 4'd0;
            oe_q        <= 4'd0;
        end else begin
            sync_q[0] <= {bus.spi_cs_n, bus.spi_clk, bus.spi_data_in};
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
            state_q     <= state_d;
            bits_q      <= bits_d;
            mode_q      <= mode_d;
            drive_q     <= drive_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_strobe_q <= rx_strobe_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            tx_ready_q  <= tx_ready_d;
            underrun_q  <= underrun_d;
            cs_start_q  <= cs_start_d;
            cs_end_q    <= cs_end_d;
            data_out_q  <= data_out_d;
            oe_q        <= oe_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bits_d      = bits_q;
        mode_d      = mode_q;
        drive_d     = drive_q;
        rx_shift_d  = rx_shift_q;
        rx_byte_d   = rx_byte_q;
        rx_strobe_d = 1'b0;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        tx_ready_d  = tx_ready_q;
        underrun_d  = 1'b0;
        cs_start_d  = 1'b0;
        cs_end_d    = 1'b0;
        load_tx     = 1'b0;

        cs_fall   = cs_prev_q & ~cs_s;
        cs_rise   = ~cs_prev_q & cs_s;
        sclk_rise = ~sclk_prev_q & sclk_s;
        sclk_fall = sclk_prev_q & ~sclk_s;
        bits_sum  = 3'(bits_q + mode_q);

        case (bus.spi_mode_in)
            3'd2:    mode_in_norm = 3'd2;
            3'd4:    mode_in_norm = 3'd4;
            default: mode_in_norm = 3'd1;
        endcase

        case (mode_q)
            3'd2: begin
                rx_next = {rx_shift_q[5:0], din_s[1:0]};
                tx_next = {tx_shift_q[5:0], 2'b00};
            end
            3'd4: begin
                rx_next = {rx_shift_q[3:0], din_s};
                tx_next = {tx_shift_q[3:0], 4'h0};
            end
            default: begin
                rx_next = {rx_shift_q, din_s[0]};
                tx_next = {tx_shift_q[6:0], 1'b0};
            end
        endcase

        // A !CS rise wins over any SCLK edge seen in the same cycle.
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d    = ACTIVE;
                    cs_start_d = 1'b1;
                    bits_d     = 3'd0;
                    mode_d     = mode_in_norm;
                    drive_d    = bus.spi_drive_in;
                    load_tx    = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d  = IDLE;
                    cs_end_d = 1'b1;
                    bits_d   = 3'd0;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_next[6:0];
                    bits_d     = bits_sum;
                    if (bits_sum == 3'd0) begin
                        rx_byte_d   = rx_next;
                        rx_strobe_d = 1'b1;
                        mode_d      = mode_in_norm;
                        drive_d     = bus.spi_drive_in;
                    end
                end else if (sclk_fall) begin
                    if (bits_q == 3'd0) load_tx = 1'b1;
                    else                tx_shift_d = tx_next;
                end
            end
            default: state_d = IDLE;
        endcase

        // An empty holding register sends 0xFF unless a strobe lands on the load cycle.
        if (load_tx) begin
            if (!tx_ready_q) begin
                tx_shift_d = hold_q;
                tx_ready_d = 1'b1;
            end else if (bus.spi_byte_tx_strobe) begin
                tx_shift_d = bus.spi_byte_tx;
            end else begin
                tx_shift_d = 8'hFF;
                underrun_d = 1'b1;
            end
        end
        if (bus.spi_byte_tx_strobe && !(load_tx && tx_ready_q)) begin
            hold_d     = bus.spi_byte_tx;
            tx_ready_d = 1'b0;
        end

        oe_d = 4'b0000;
        if (state_d == ACTIVE && drive_d) begin
            case (mode_d)
                3'd2:    oe_d = 4'b0011;
                3'd4:    oe_d = 4'b1111;
                default: oe_d = 4'b0010;
            endcase
        end
        case (mode_d)
            3'd2:    lanes = {2'b00, tx_shift_d[7:6]};
            3'd4:    lanes = tx_shift_d[7:4];
            default: lanes = {2'b00, tx_shift_d[7], 1'b0};
        endcase
        data_out_d = lanes & oe_d;
    end

    assign bus.spi_data_out       = data_out_q;
    assign bus.spi_data_oe        = oe_q;
    assign bus.spi_tx_ready       = tx_ready_q;
    assign bus.spi_tx_underrun    = underrun_q;
    assign bus.spi_byte_rx_strobe = rx_strobe_q;
    assign bus.spi_byte_rx        = rx_byte_q;
    assign bus.spi_cs_start       = cs_start_q;
    assign bus.spi_cs_end         = cs_end_q;
endmodule

// File: doc/spi_responder.md
# spi_responder

Peripheral (flash-side) end of the single/dual/quad SPI link: samples an externally driven !CS, SCLK and data bus, assembles received bytes, and shifts out transmit bytes, in SPI mode 0 (CPOL=0, CPHA=0). It is the counterpart of the SPI controller. It lets the FPGA emulate a flash device toward a host chipset, with command/address decode handled by the logic above it. All pin inputs are asynchronous to `clk` and are synchronized internally.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop stages on `spi_cs_n`, `spi_clk`, `spi_data_in` (≥2).

Ports:
- `clk`  in  1  system clock; SCLK must be ≤ clk/8
- `reset`  in  1  synchronous, active-high
- `spi_cs_n`  in  1  chip select from host, active low
- `spi_clk`  in  1  SCLK from host, idle low
- `spi_data_in`  in  4  pin inputs D3..D0 (D0=DI, D1=DO)
- `spi_data_out`  out  4  pin output values
- `spi_data_oe`  out  4  per-pin output enable
- `spi_mode_in`  in  3  bits per SCLK for the next byte: 1, 2 or 4
- `spi_drive_in`  in  1  1 = next byte is a device-to-host (output) byte
- `spi_byte_tx_strobe`  in  1  load `spi_byte_tx` into the holding register
- `spi_byte_tx`  in  8  transmit byte
- `spi_tx_ready`  out  1  holding register empty
- `spi_tx_underrun`  out  1  one-cycle pulse: byte load with empty holding register
- `spi_byte_rx_strobe`  out  1  one-cycle pulse: `spi_byte_rx` valid
- `spi_byte_rx`  out  8  last complete received byte (held)
- `spi_cs_start`  out  1  one-cycle pulse on synchronized !CS fall
- `spi_cs_end`  out  1  one-cycle pulse on synchronized !CS rise

## Operation
- States: IDLE (!CS high), ACTIVE (!CS low). IDLE→ACTIVE on synchronized !CS fall. ACTIVE→IDLE on synchronized !CS rise.
- Edge detect: register the synchronized SCLK. A rise occurs when prev=0 and cur=1; a fall when prev=1 and cur=0. Edges are ignored in IDLE.
- Mode/drive latch: `spi_mode_in`/`spi_drive_in` are captured at !CS fall and at every byte completion. They hold for the whole byte. Mode values other than 1, 2 or 4 are treated as 1.
- Receive (on SCLK rise): mode 1 shifts in D0, mode 2 shifts in {D1,D0}, mode 4 shifts in D[3:0], MSB first. `bits` (3 bit) += mode and wraps mod 8. When it wraps to 0: `spi_byte_rx` ← the assembled byte, pulse `spi_byte_rx_strobe`, relatch mode/drive.
- Transmit load: at !CS fall, and at each SCLK fall with `bits`==0, the tx shift register ← holding register and `spi_tx_ready` returns to 1. If the holding register is empty, the shift register loads 0xFF and `spi_tx_underrun` pulses. If a strobe arrives in the same cycle as a load while the register is empty, the strobed byte bypasses into the shift register (no underrun).
- Transmit shift (SCLK fall, `bits`≠0): shift left by mode.
- Output mapping: mode 1 drives shift[7] on D1. Mode 2 drives shift[7:6] on {D1,D0}. Mode 4 drives shift[7:4] on D[3:0]. Undriven lanes are 0.
- OE: when drive=0 or IDLE, OE=0000. Otherwise mode 1→0010, mode 2→0011, mode 4→1111.
- Holding register: `spi_byte_tx_strobe` writes it and clears `spi_tx_ready`. A strobe while not ready overwrites the byte.
- !CS rise mid-byte: the partial byte is discarded without a strobe. `bits`←0, OE←0000, pulse `spi_cs_end`. The holding register is kept.

## Timing
- Reset values: `spi_data_out`=0, `spi_data_oe`=0, `spi_byte_rx`=0, all strobes 0, `spi_tx_ready`=1, state IDLE, `bits`=0, latched mode=1, drive=0.
- Pin-to-event latency: SYNC_STAGES+1 `clk` cycles, which is 3 at default. This applies from a pin edge to the resulting strobe, pulse, or output change.
- `spi_byte_rx_strobe` asserts 3 cycles after the final SCLK rise of a byte. `spi_byte_rx` is stable from that cycle until the next strobe.
- To be sent, the next tx byte must be strobed before the SCLK fall that follows the last rise of the current byte.
- A !CS rise has priority over any SCLK edge detected in the same cycle.
- `reset` overrides everything and is honoured in the same cycle, including mid-transfer.

## Test plan
- Single-mode receive: !CS low, host clocks 0xA5 on D0 at clk/8 → one `spi_byte_rx_strobe`, `spi_byte_rx`=0xA5, OE=0000 throughout.
- Single-mode transmit: strobe 0x3C with drive=1 before !CS fall → D1 shows 0,0,1,1,1,1,0,0 on successive rises, OE=0010, `spi_tx_ready` goes 1 at !CS+3.
- Quad: mode 4, drive=0 for the byte 0xEB, then mode 4, drive=1 with tx 0x5A → rx strobe 0xEB after 2 rises, D[3:0] then shows 5,A, OE=1111.
- Underrun/bypass: no strobe at the byte boundary → 0xFF sent, one `spi_tx_underrun` pulse. Strobe coinciding with the load cycle → strobed byte sent, no pulse.
- Abort: !CS rises after 5 bits → no rx strobe, `spi_cs_end` pulse, OE=0000. The next transaction receives 0x81 correctly.
- Reset after 4 bits → all outputs return to reset values in the same cycle. A fresh 0x00 byte is received correctly.
